// File: rtl/pipe_ctrl_n_if.sv
// Handshake and bus bundle between the pipeline controller and its surroundings.
// The master drives entry/exit control; the slave (controller) returns pipeline state.
interface pipe_ctrl_n_if #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned BUS_W  = 64,
    parameter int unsigned SW     = 3
);
    logic                      in_valid;
    logic                      in_ready;
    logic [BUS_W-1:0]          in_bus;
    logic [STAGES-1:0]         stage_over;
    logic [STAGES-1:0]         stage_valid;
    logic [STAGES-1:0]         allow_in;
    logic [STAGES*BUS_W-1:0]   stage_bus;
    logic                      out_valid;
    logic                      out_ready;
    logic [BUS_W-1:0]          out_bus;
    logic                      flush;
    logic [SW-1:0]             flush_stage;
    logic [SW-1:0]             occupancy;
    logic [31:0]               stall_cnt;

    modport master (
        output in_valid, in_bus, stage_over, out_ready, flush, flush_stage,
        input  in_ready, stage_valid, allow_in, stage_bus, out_valid, out_bus,
               occupancy, stall_cnt
    );

    modport slave (
        input  in_valid, in_bus, stage_over, out_ready, flush, flush_stage,
        output in_ready, stage_valid, allow_in, stage_bus, out_valid, out_bus,
               occupancy, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_n.sv
// N-stage valid/allow_in pipeline controller with per-stage bus latches,
// partial flush (stage 0..k), exit backpressure, occupancy and entry-stall statistics.
module pipe_ctrl_n #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned BUS_W  = 64,
    parameter int unsigned SW     = 3
) (
    input  logic          clk,
    input  logic          resetn,
    pipe_ctrl_n_if.slave  p
);
    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0][BUS_W-1:0]  bus_q,   bus_d;
    logic [SW-1:0]                 occ_q,   occ_d;
    logic [31:0]                   stall_q, stall_d;

    logic [STAGES-1:0]             over_c;
    logic [STAGES-1:0]             allow_c;
    logic [STAGES-1:0]             kill_c;
    logic [STAGES-2:0]             xfer_c;
    logic                          in_ready_c;

    // Handshake chain: a stage accepts when empty or its occupant leaves this edge.
    // Gating stage_over with valid keeps X on empty stages out of the chain.
    always_comb begin
        int unsigned idx;
        idx           = 0;
        over_c        = valid_q & p.stage_over;
        allow_c       = '0;
        allow_c[LAST] = ~valid_q[LAST] | (over_c[LAST] & p.out_ready);
        for (int unsigned n = 0; n < LAST; n++) begin
            idx          = LAST - 1 - n;
            allow_c[idx] = ~valid_q[idx] | (over_c[idx] & allow_c[idx+1]);
        end
        for (int unsigned j = 0; j < STAGES; j++) begin
            kill_c[j] = p.flush & (32'(p.flush_stage) >= j);
        end
        for (int unsigned j = 0; j < LAST; j++) begin
            xfer_c[j] = over_c[j] & ~kill_c[j] & allow_c[j+1];
        end
        in_ready_c = allow_c[0] & ~p.flush;
    end

    // Next-state: kill dominates, then advance/bubble, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        bus_d   = bus_q;
        occ_d   = '0;
        stall_d = stall_q;

        if (kill_c[0]) begin
            valid_d[0] = 1'b0;
        end else if (in_ready_c) begin
            valid_d[0] = p.in_valid;
            if (p.in_valid) begin
                bus_d[0] = p.in_bus;
            end
        end

        for (int unsigned j = 1; j < STAGES; j++) begin
            if (kill_c[j]) begin
                valid_d[j] = 1'b0;
            end else if (allow_c[j]) begin
                valid_d[j] = xfer_c[j-1];
                if (xfer_c[j-1]) begin
                    bus_d[j] = bus_q[j-1];
                end
            end
        end

        for (int unsigned j = 0; j < STAGES; j++) begin
            occ_d = occ_d + SW'(valid_d[j]);
        end

        if (p.in_valid & ~in_ready_c & ~p.flush & (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            bus_q   <= '0;
            occ_q   <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            bus_q   <= bus_d;
            occ_q   <= occ_d;
            stall_q <= stall_d;
        end
    end

    assign p.in_ready    = in_ready_c;
    assign p.stage_valid = valid_q;
    assign p.allow_in    = allow_c;
    assign p.stage_bus   = bus_q;
    assign p.out_valid   = over_c[LAST];
    assign p.out_bus     = bus_q[LAST];
    assign p.occupancy   = occ_q;
    assign p.stall_cnt   = stall_q;
endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Bench for pipe_ctrl_n: slot-based item model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_pipe_ctrl_n;
    localparam int unsigned STAGES = 5;
    localparam int unsigned BUS_W  = 64;
    localparam int unsigned SW     = 3;
    localparam int          N      = 5;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_n_if #(.STAGES(STAGES), .BUS_W(BUS_W), .SW(SW)) p();

    pipe_ctrl_n #(.STAGES(STAGES), .BUS_W(BUS_W), .SW(SW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .p      (p)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Item model: each slot holds an item or nothing; items move toward the exit.
    bit                mv [N];
    logic [BUS_W-1:0]  mb [N];
    logic [31:0]       mstall = '0;
    bit                fr [N];
    logic [BUS_W-1:0]  m_ret[$];
    logic [BUS_W-1:0]  d_ret[$];

    // fr[i]: slot i can take a new item this edge (empty, or its item moves on).
    function automatic void calc_fr();
        for (int i = N - 1; i >= 0; i--) begin
            bit dest_ok;
            if (i == N - 1) dest_ok = (p.out_ready === 1'b1);
            else            dest_ok = fr[i+1];
            fr[i] = !mv[i] || ((p.stage_over[i] === 1'b1) && dest_ok);
        end
    endfunction

    function automatic int kill_limit();
        if (p.flush !== 1'b1) return -1;
        if (32'(p.flush_stage) >= STAGES) return N - 1;
        return int'(p.flush_stage);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                mv[i] <= 1'b0;
                mb[i] <= '0;
            end
            mstall <= '0;
        end else begin
            bit               nv [N];
            logic [BUS_W-1:0] nb [N];
            int               kk;
            calc_fr();
            kk = kill_limit();
            for (int i = 0; i < N; i++) begin
                nv[i] = 1'b0;
                nb[i] = mb[i];
            end
            for (int i = N - 1; i >= 0; i--) begin
                if (mv[i]) begin
                    bit leaves;
                    if (i == N - 1) leaves = (p.stage_over[i] === 1'b1) && (p.out_ready === 1'b1);
                    else            leaves = (p.stage_over[i] === 1'b1) && fr[i+1];
                    if (!leaves) begin
                        nv[i] = 1'b1;
                    end else if (i > kk) begin
                        if (i == N - 1) m_ret.push_back(mb[i]);
                        else begin
                            nv[i+1] = 1'b1;
                            nb[i+1] = mb[i];
                        end
                    end
                end
            end
            for (int i = 0; i < N; i++) if (i <= kk) nv[i] = 1'b0;
            if (fr[0] && (p.flush !== 1'b1) && (p.in_valid === 1'b1)) begin
                nv[0] = 1'b1;
                nb[0] = p.in_bus;
            end
            if ((p.in_valid === 1'b1) && (p.flush !== 1'b1) && !fr[0] && (mstall != 32'hFFFF_FFFF))
                mstall <= mstall + 32'd1;
            mv <= nv;
            mb <= nb;
        end
    end

    // Retirements as the DUT actually presents them.
    always @(posedge clk) begin
        if (resetn && (p.out_valid === 1'b1) && (p.out_ready === 1'b1) &&
            !((p.flush === 1'b1) && (32'(p.flush_stage) >= STAGES - 1)))
            d_ret.push_back(p.out_bus);
    end

    // Per-cycle comparison against the model, mid-cycle away from the edge.
    always @(negedge clk) begin
        logic [N-1:0] ev, ea;
        int           cnt;
        calc_fr();
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            ev[i] = mv[i];
            ea[i] = fr[i];
            cnt  += int'(mv[i]);
        end
        chk("cyc_stage_valid", 64'(p.stage_valid), 64'(ev));
        chk("cyc_allow_in",    64'(p.allow_in),    64'(ea));
        chk("cyc_in_ready",    64'(p.in_ready),    64'(fr[0] && (p.flush !== 1'b1)));
        chk("cyc_out_valid",   64'(p.out_valid),   64'(mv[N-1] && (p.stage_over[N-1] === 1'b1)));
        chk("cyc_occupancy",   64'(p.occupancy),   64'(cnt));
        chk("cyc_stall_cnt",   64'(p.stall_cnt),   64'(mstall));
        if (mv[N-1]) chk("cyc_out_bus", p.out_bus, mb[N-1]);
        for (int i = 0; i < N; i++)
            if (mv[i]) chk($sformatf("cyc_stage_bus%0d", i), p.stage_bus[i*BUS_W +: BUS_W], mb[i]);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int          peak;
    logic [31:0] s0;

    initial begin
        for (int i = 0; i < N; i++) mb[i] = '0;
        p.in_valid    = 1'b0;
        p.in_bus      = '0;
        p.stage_over  = 'x;
        p.out_ready   = 1'b1;
        p.flush       = 1'b0;
        p.flush_stage = '0;

        // Reset values
        #3;
        chk("rst_stage_valid", 64'(p.stage_valid), 64'h0);
        chk("rst_occupancy",   64'(p.occupancy),   64'h0);
        chk("rst_stall_cnt",   64'(p.stall_cnt),   64'h0);
        chk("rst_out_valid",   64'(p.out_valid),   64'h0);
        for (int i = 0; i < N; i++) chk("rst_stage_bus", p.stage_bus[i*BUS_W +: BUS_W], 64'h0);
        #9 resetn = 1'b1;

        // Test 1: single item latency (stage_over is X while pipe empty)
        step(1);
        p.stage_over = '1;
        p.in_valid   = 1'b1;
        p.in_bus     = 64'hA1;
        step(1);
        p.in_valid = 1'b0;
        p.in_bus   = '0;
        chk("t1_stage0", 64'(p.stage_valid), 64'h01);
        step(4);
        chk("t1_out_valid",   64'(p.out_valid),   64'h1);
        chk("t1_out_bus",     p.out_bus,          64'hA1);
        chk("t1_stage_valid", 64'(p.stage_valid), 64'h10);
        step(1);
        chk("t1_retired", 64'(p.stage_valid), 64'h0);

        // Test 2: back-to-back stream
        d_ret.delete();
        m_ret.delete();
        peak = 0;
        for (int v = 1; v <= 8; v++) begin
            p.in_valid = 1'b1;
            p.in_bus   = 64'(v);
            step(1);
            if (int'(p.occupancy) > peak) peak = int'(p.occupancy);
        end
        p.in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (int'(p.occupancy) > peak) peak = int'(p.occupancy);
        end
        chk("t2_peak_occ", 64'(peak), 64'd5);
        chk("t2_ret_count", 64'(d_ret.size()), 64'd8);
        chk("t2_model_count", 64'(m_ret.size()), 64'd8);
        for (int v = 0; v < 8 && v < d_ret.size(); v++) chk("t2_ret_order", d_ret[v], 64'(v + 1));
        for (int v = 0; v < 8 && v < m_ret.size(); v++) chk("t2_model_order", m_ret[v], 64'(v + 1));

        // Test 3: stage 2 not over for 3 cycles with a full pipe
        for (int v = 0; v < 5; v++) begin
            p.in_valid = 1'b1;
            p.in_bus   = 64'h10 + 64'(v);
            step(1);
        end
        chk("t3_full", 64'(p.occupancy), 64'd5);
        p.in_bus     = 64'h20;
        p.stage_over = 5'b11011;
        s0 = p.stall_cnt;
        step(3);
        chk("t3_stall_delta", 64'(p.stall_cnt - s0), 64'd3);
        chk("t3_stage_valid", 64'(p.stage_valid), 64'h07);
        chk("t3_stage2_bus",  p.stage_bus[2*BUS_W +: BUS_W], 64'h12);
        p.stage_over = '1;

        // Test 4: partial flush of stages 0..1 with a full pipe
        for (int v = 0; v < 6; v++) begin
            p.in_bus = 64'h30 + 64'(v);
            step(1);
        end
        chk("t4_full", 64'(p.occupancy), 64'd5);
        p.flush       = 1'b1;
        p.flush_stage = 3'd1;
        p.in_bus      = 64'h99;
        #1;
        chk("t4_in_ready", 64'(p.in_ready), 64'h0);
        step(1);
        p.flush    = 1'b0;
        p.in_valid = 1'b0;
        chk("t4_stage_valid", 64'(p.stage_valid), 64'h18);
        chk("t4_occupancy",   64'(p.occupancy),   64'd2);
        step(4);

        // Test 5: flush_stage beyond the last stage kills everything
        for (int v = 0; v < 6; v++) begin
            p.in_valid = 1'b1;
            p.in_bus   = 64'h40 + 64'(v);
            step(1);
        end
        chk("t5_full", 64'(p.occupancy), 64'd5);
        p.flush       = 1'b1;
        p.flush_stage = 3'd7;
        step(1);
        p.flush       = 1'b0;
        p.flush_stage = '0;
        p.in_valid    = 1'b0;
        chk("t5_stage_valid", 64'(p.stage_valid), 64'h0);
        chk("t5_occupancy",   64'(p.occupancy),   64'h0);

        // Test 6: exit backpressure then asynchronous reset mid-stream
        for (int v = 0; v < 6; v++) begin
            p.in_valid = 1'b1;
            p.in_bus   = 64'h50 + 64'(v);
            step(1);
        end
        p.out_ready = 1'b0;
        p.in_bus    = 64'h60;
        s0 = p.stall_cnt;
        step(4);
        chk("t6_occupancy",  64'(p.occupancy), 64'd5);
        chk("t6_in_ready",   64'(p.in_ready),  64'h0);
        chk("t6_stall_delta", 64'(p.stall_cnt - s0), 64'd4);
        chk("t6_head_bus",   p.out_bus, 64'h51);
        p.out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            p.in_bus = 64'h70 + 64'(v);
            step(1);
        end
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_valid",     64'(p.stage_valid), 64'h0);
        chk("t6_rst_occupancy", 64'(p.occupancy),   64'h0);
        chk("t6_rst_stall",     64'(p.stall_cnt),   64'h0);
        chk("t6_rst_out_valid", 64'(p.out_valid),   64'h0);
        chk("t6_rst_out_bus",   p.out_bus,          64'h0);
        for (int i = 0; i < N; i++) chk("t6_rst_stage_bus", p.stage_bus[i*BUS_W +: BUS_W], 64'h0);
        p.in_valid = 1'b0;
        step(2);
        resetn = 1'b1;
        step(3);

        // Every retirement the DUT presented must match the model, in order
        chk("end_ret_count", 64'(d_ret.size()), 64'(m_ret.size()));
        for (int i = 0; i < d_ret.size() && i < m_ret.size(); i++)
            chk("end_ret_item", d_ret[i], m_ret[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
